// File: rtl/trivium_pkg.sv
// Shared types and constants for the Trivium keystream packer.
package trivium_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WARMUP,
    COLLECT,
    DONE
  } packer_state_t;

  localparam int unsigned TRIVIUM_KEY_W       = 80;
  localparam int unsigned TRIVIUM_IV_W        = 80;
  localparam int unsigned TRIVIUM_WARMUP_BITS = 1152;

endpackage

// File: rtl/ks_shift_reg.sv
// Shift-in register: new beat enters at the LSB end, oldest bits drift to the MSB.
// 'shifted' is the value the register takes on an enabled edge, so a caller can
// capture the completed word on the same edge as the final shift.
module ks_shift_reg #(
  parameter int unsigned Width  = 64,
  parameter int unsigned ShiftW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [ShiftW-1:0] din,
  output logic [Width-1:0]  shifted
);

  logic [Width-1:0] sh_q;

  // Next value with the new beat appended; a single-beat word is just the beat.
  if (Width == ShiftW) begin : g_full_beat
    assign shifted = din;
  end else begin : g_partial_beat
    assign shifted = {sh_q[Width-ShiftW-1:0], din};
  end

  // Register update: clear has priority over shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= '0;
    end else if (clr) begin
      sh_q <= '0;
    end else if (en) begin
      sh_q <= shifted;
    end
  end

endmodule

// File: rtl/trivium_keystream_packer.sv
// Sequences a Trivium core through load and warm-up, then packs the next
// DATA_WIDTH keystream bits into one block and holds it with end_block.
module trivium_keystream_packer
  import trivium_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned WARMUP_BITS    = TRIVIUM_WARMUP_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [BITS_PER_CYCLE-1:0] ks_i,
  input  logic                      ks_valid_i,
  output logic                      core_load_o,
  output logic                      core_en_o,
  output logic [DATA_WIDTH-1:0]     block_o,
  output logic                      end_block
);

  localparam int unsigned WarmBeats = WARMUP_BITS / BITS_PER_CYCLE;
  localparam int unsigned CollBeats = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int unsigned MaxBeats  = (WarmBeats > CollBeats) ? WarmBeats : CollBeats;
  localparam int unsigned CntW      = $clog2(MaxBeats + 1);
  localparam logic [CntW-1:0] WarmLast = CntW'(WarmBeats - 1);
  localparam logic [CntW-1:0] CollLast = CntW'(CollBeats - 1);

  if (BITS_PER_CYCLE == 0 || DATA_WIDTH < BITS_PER_CYCLE ||
      (DATA_WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_data_width
    $error("DATA_WIDTH must be a non-zero multiple of BITS_PER_CYCLE");
  end
  if (BITS_PER_CYCLE == 0 || WARMUP_BITS < BITS_PER_CYCLE ||
      (WARMUP_BITS % BITS_PER_CYCLE) != 0) begin : g_bad_warmup
    $error("WARMUP_BITS must be a non-zero multiple of BITS_PER_CYCLE");
  end

  packer_state_t             state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      sh_clr, sh_en, blk_clr, blk_load;
  logic [DATA_WIDTH-1:0]     sh_next;
  logic [DATA_WIDTH-1:0]     block_q;
  logic                      end_q;

  ks_shift_reg #(
    .Width  (DATA_WIDTH),
    .ShiftW (BITS_PER_CYCLE)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .clr     (sh_clr),
    .en      (sh_en),
    .din     (ks_i),
    .shifted (sh_next)
  );

  // State and beat counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter control and Moore core controls.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_clr      = 1'b0;
    sh_en       = 1'b0;
    blk_clr     = 1'b0;
    blk_load    = 1'b0;
    core_load_o = 1'b0;
    core_en_o   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        // Clearing on the way into LOAD makes the old block vanish the same
        // cycle the load pulse appears.
        if (start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
          sh_clr  = 1'b1;
          blk_clr = 1'b1;
        end
      end
      LOAD: begin
        core_load_o = 1'b1;
        cnt_d       = '0;
        sh_clr      = 1'b1;
        state_d     = WARMUP;
      end
      WARMUP: begin
        core_en_o = 1'b1;
        if (ks_valid_i) begin
          if (cnt_q == WarmLast) begin
            cnt_d   = '0;
            state_d = COLLECT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COLLECT: begin
        core_en_o = 1'b1;
        if (ks_valid_i) begin
          sh_en = 1'b1;
          if (cnt_q == CollLast) begin
            cnt_d    = '0;
            blk_load = 1'b1;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output block: only ever zero or a completed word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_q <= '0;
      end_q   <= 1'b0;
    end else if (blk_clr) begin
      block_q <= '0;
      end_q   <= 1'b0;
    end else if (blk_load) begin
      block_q <= sh_next;
      end_q   <= 1'b1;
    end
  end

  assign block_o   = block_q;
  assign end_block = end_q;

endmodule

// File: tb/tb_trivium_keystream_packer.sv
// Directed bench for trivium_keystream_packer: default-width instance plus an
// 8-bit-per-beat instance sharing clock and reset.
module tb_trivium_keystream_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, ks, vld;
  logic        load, en, endb;
  logic [63:0] blk;
  logic        start8, vld8;
  logic [7:0]  ks8;
  logic        load8, en8, endb8;
  logic [63:0] blk8;

  int checks = 0;
  int fails  = 0;

  // Results captured by run_def.
  int          r_rise, r_loads;
  bit          r_early;
  logic [63:0] r_blk;
  logic        r_p0_end, r_p0_load;
  logic [63:0] r_p0_blk;
  logic        r_ab_load, r_ab_en, r_ab_end;
  logic [63:0] r_ab_blk;

  always #5 clk = ~clk;

  trivium_keystream_packer dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .ks_i        (ks),
    .ks_valid_i  (vld),
    .core_load_o (load),
    .core_en_o   (en),
    .block_o     (blk),
    .end_block   (endb)
  );

  trivium_keystream_packer #(
    .DATA_WIDTH     (64),
    .BITS_PER_CYCLE (8),
    .WARMUP_BITS    (1152)
  ) dut8 (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start8),
    .ks_i        (ks8),
    .ks_valid_i  (vld8),
    .core_load_o (load8),
    .core_en_o   (en8),
    .block_o     (blk8),
    .end_block   (endb8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %0s: observed %0h expected %0h", name, got, want);
    end
  endtask

  // One run on the default instance. Edge 0 samples start; ks_i carries the
  // chosen pattern from the first collect beat (beat 1152), random before.
  task automatic run_def(input bit stall, input bit pulse, input int pat, input int abort_edge);
    int beats;
    int k;
    logic [63:0] p1;
    p1      = 64'hDEAD_BEEF_0123_4567;
    beats   = 0;
    r_rise  = -1;
    r_loads = 0;
    r_early = 1'b0;
    start   = 1'b1;
    vld     = 1'b0;
    ks      = 1'b0;
    step();
    start     = 1'b0;
    r_p0_end  = endb;
    r_p0_blk  = blk;
    r_p0_load = load;
    if (load) r_loads++;
    for (int e = 1; e < 3000; e++) begin
      vld = (e >= 2) && (!stall || (e % 2 == 0));
      k   = beats - 1152;
      if (k >= 0 && k < 64) ks = (pat == 0) ? ~k[0] : p1[63-k];
      else                  ks = 1'($urandom_range(0, 1));
      start = pulse && (e == 500 || e == 1180);
      step();
      if (vld) beats++;
      if (load) r_loads++;
      if (e == abort_edge) begin
        rst = 1'b1;
        #1;
        r_ab_load = load;
        r_ab_en   = en;
        r_ab_end  = endb;
        r_ab_blk  = blk;
        #1;
        rst   = 1'b0;
        vld   = 1'b0;
        start = 1'b0;
        return;
      end
      if (endb) begin
        r_rise = e;
        break;
      end
      if (blk !== 64'h0) r_early = 1'b1;
    end
    start = 1'b0;
    vld   = 1'b0;
    r_blk = blk;
  endtask

  initial begin
    logic [63:0] b8;
    int          rise8;
    int          k8;
    b8     = 64'h0123_4567_89AB_CDEF;
    rst    = 1'b1;
    start  = 1'b0;
    ks     = 1'b0;
    vld    = 1'b0;
    start8 = 1'b0;
    ks8    = 8'h00;
    vld8   = 1'b0;
    #2;
    chk("reset core_load", 64'(load), 64'h0);
    chk("reset core_en", 64'(en), 64'h0);
    chk("reset end_block", 64'(endb), 64'h0);
    chk("reset block", blk, 64'h0);
    chk("reset block8", blk8, 64'h0);
    rst = 1'b0;

    // Plain run, alternating 1,0 collect data.
    run_def(1'b0, 1'b0, 0, -1);
    chk("run1 load at cycle1", 64'(r_p0_load), 64'h1);
    chk("run1 rise edge", 64'(r_rise), 64'd1217);
    chk("run1 block", r_blk, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("run1 load pulses", 64'(r_loads), 64'd1);
    chk("run1 no partial block", 64'(r_early), 64'h0);
    chk("run1 done core_en", 64'(en), 64'h0);
    for (int i = 0; i < 5; i++) step();
    chk("run1 end held", 64'(endb), 64'h1);
    chk("run1 block held", blk, 64'hAAAA_AAAA_AAAA_AAAA);

    // Restart straight from DONE with different data.
    run_def(1'b0, 1'b0, 1, -1);
    chk("restart end cleared", 64'(r_p0_end), 64'h0);
    chk("restart block cleared", r_p0_blk, 64'h0);
    chk("restart load", 64'(r_p0_load), 64'h1);
    chk("run2 rise edge", 64'(r_rise), 64'd1217);
    chk("run2 block", r_blk, 64'hDEAD_BEEF_0123_4567);

    // Valid low every other cycle.
    run_def(1'b1, 1'b0, 0, -1);
    chk("stall rise edge", 64'(r_rise), 64'd2432);
    chk("stall block", r_blk, 64'hAAAA_AAAA_AAAA_AAAA);

    // start pulses during warm-up and collect are ignored.
    run_def(1'b0, 1'b1, 0, -1);
    chk("pulse rise edge", 64'(r_rise), 64'd1217);
    chk("pulse load pulses", 64'(r_loads), 64'd1);
    chk("pulse block", r_blk, 64'hAAAA_AAAA_AAAA_AAAA);

    // Reset in the middle of collection, then a full run.
    run_def(1'b0, 1'b0, 0, 1190);
    chk("abort core_load", 64'(r_ab_load), 64'h0);
    chk("abort core_en", 64'(r_ab_en), 64'h0);
    chk("abort end_block", 64'(r_ab_end), 64'h0);
    chk("abort block", r_ab_blk, 64'h0);
    step();
    chk("post-abort idle core_en", 64'(en), 64'h0);
    run_def(1'b0, 1'b0, 1, -1);
    chk("post-abort rise edge", 64'(r_rise), 64'd1217);
    chk("post-abort block", r_blk, 64'hDEAD_BEEF_0123_4567);

    // Byte-wide instance: 144 warm-up beats then 8 collect beats.
    rise8  = -1;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    chk("b8 load at cycle1", 64'(load8), 64'h1);
    vld8 = 1'b1;
    for (int e = 1; e < 400; e++) begin
      k8 = e - 146;
      if (k8 >= 0 && k8 < 8) ks8 = b8[63-8*k8 -: 8];
      else                   ks8 = 8'($urandom_range(0, 255));
      step();
      if (endb8) begin
        rise8 = e;
        break;
      end
    end
    vld8 = 1'b0;
    chk("b8 rise edge", 64'(rise8), 64'd153);
    chk("b8 block", blk8, 64'h0123_4567_89AB_CDEF);
    chk("b8 done core_en", 64'(en8), 64'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
